// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with built-in load-use hazard detection.
//
// Each rising edge latches the decoded operands, register addresses and
// control bits from ID. A bubble is loaded instead in two cases:
//   - on a branch flush (flush_i);
//   - on a load-use hazard (hazard_o).
// The registered RS/RT/WB addresses feed the forwarding unit.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   flush_i             squash the instruction currently in ID
//   RSdata_i..imm_i     decoded operands / sign-extended immediate
//   RSaddr_i..RDaddr_i  IF/ID register fields
//   RegWrite_i..ALUOp_i decoded control
//   *_o                 registered copies for EX
//   WBaddr_o            destination chosen at latch time (RD if RegDst, else RT)
//   valid_o             EX holds a real instruction (not a bubble)
//   hazard_o            combinational hold request for PC and IF/ID
//   stall_cnt_o         saturating count of hazard cycles
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] RSaddr_i,
    input  logic [REG_AW-1:0] RTaddr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic              RegDst_i,
    input  logic [1:0]        ALUOp_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_AW-1:0] RSaddr_o,
    output logic [REG_AW-1:0] RTaddr_o,
    output logic [REG_AW-1:0] WBaddr_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic              valid_o,
    output logic              hazard_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic raw_hazard;
    logic load_bubble;

    // The load in EX writes RTaddr_o. $0 is never a real dependency.
    assign raw_hazard = MemRead_o && (RTaddr_o != '0) &&
                        ((RTaddr_o == RSaddr_i) || (RTaddr_o == RTaddr_i));

    // A flushed instruction is discarded anyway, so it must not hold the front end.
    assign hazard_o    = raw_hazard && !flush_i;
    assign load_bubble = flush_i || hazard_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RSdata_o    <= '0;
            RTdata_o    <= '0;
            imm_o       <= '0;
            RSaddr_o    <= '0;
            RTaddr_o    <= '0;
            WBaddr_o    <= '0;
            RegWrite_o  <= 1'b0;
            MemtoReg_o  <= 1'b0;
            MemRead_o   <= 1'b0;
            MemWrite_o  <= 1'b0;
            ALUSrc_o    <= 1'b0;
            ALUOp_o     <= 2'b00;
            valid_o     <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            // Data fields are don't-care in a bubble, so they always load.
            RSdata_o <= RSdata_i;
            RTdata_o <= RTdata_i;
            imm_o    <= imm_i;

            if (load_bubble) begin
                // Zeroed addresses keep the forwarding unit from matching a bubble.
                RSaddr_o   <= '0;
                RTaddr_o   <= '0;
                WBaddr_o   <= '0;
                RegWrite_o <= 1'b0;
                MemtoReg_o <= 1'b0;
                MemRead_o  <= 1'b0;
                MemWrite_o <= 1'b0;
                ALUSrc_o   <= 1'b0;
                ALUOp_o    <= 2'b00;
                valid_o    <= 1'b0;
            end else begin
                RSaddr_o   <= RSaddr_i;
                RTaddr_o   <= RTaddr_i;
                WBaddr_o   <= RegDst_i ? RDaddr_i : RTaddr_i;
                RegWrite_o <= RegWrite_i;
                MemtoReg_o <= MemtoReg_i;
                MemRead_o  <= MemRead_i;
                MemWrite_o <= MemWrite_i;
                ALUSrc_o   <= ALUSrc_i;
                ALUOp_o    <= ALUOp_i;
                valid_o    <= 1'b1;
            end

            // Saturating count: stays at all-ones instead of wrapping.
            if (hazard_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed bench for id_ex_stage. The main instance uses the default 16-bit
// counter. A second instance has a 2-bit counter, shares the same inputs and
// is held in reset until the saturation sequence starts.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rst_small;
    logic        flush_i;
    logic [31:0] RSdata_i, RTdata_i, imm_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i;
    logic [1:0]  ALUOp_i;

    logic [31:0] RSdata_o, RTdata_o, imm_o;
    logic [4:0]  RSaddr_o, RTaddr_o, WBaddr_o;
    logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
    logic [1:0]  ALUOp_o;
    logic        valid_o, hazard_o;
    logic [15:0] stall_cnt_o;

    logic [31:0] s_RSdata_o, s_RTdata_o, s_imm_o;
    logic [4:0]  s_RSaddr_o, s_RTaddr_o, s_WBaddr_o;
    logic        s_RegWrite_o, s_MemtoReg_o, s_MemRead_o, s_MemWrite_o, s_ALUSrc_o;
    logic [1:0]  s_ALUOp_o;
    logic        s_valid_o, s_hazard_o;
    logic [1:0]  s_stall_cnt_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i),
        .ALUOp_i(ALUOp_i),
        .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .imm_o(imm_o),
        .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o), .WBaddr_o(WBaddr_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
        .valid_o(valid_o), .hazard_o(hazard_o), .stall_cnt_o(stall_cnt_o)
    );

    id_ex_stage #(.CNT_W(2)) dut_small (
        .clk_i(clk_i), .rst_i(rst_small), .flush_i(flush_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i),
        .ALUOp_i(ALUOp_i),
        .RSdata_o(s_RSdata_o), .RTdata_o(s_RTdata_o), .imm_o(s_imm_o),
        .RSaddr_o(s_RSaddr_o), .RTaddr_o(s_RTaddr_o), .WBaddr_o(s_WBaddr_o),
        .RegWrite_o(s_RegWrite_o), .MemtoReg_o(s_MemtoReg_o), .MemRead_o(s_MemRead_o),
        .MemWrite_o(s_MemWrite_o), .ALUSrc_o(s_ALUSrc_o), .ALUOp_o(s_ALUOp_o),
        .valid_o(s_valid_o), .hazard_o(s_hazard_o), .stall_cnt_o(s_stall_cnt_o)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one decoded instruction into ID. Loads and stores use the
    // immediate; other instructions are R-type ALU ops.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic regdst, input logic regwrite, input logic memread,
                         input logic memwrite, input logic [31:0] rsdata);
        RSaddr_i   = rs;
        RTaddr_i   = rt;
        RDaddr_i   = rd;
        RegDst_i   = regdst;
        RegWrite_i = regwrite;
        MemRead_i  = memread;
        MemtoReg_i = memread;
        MemWrite_i = memwrite;
        ALUSrc_i   = memread | memwrite;
        ALUOp_i    = (memread | memwrite) ? 2'b00 : 2'b10;
        RSdata_i   = rsdata;
        RTdata_i   = ~rsdata;
        imm_i      = 32'h0000_0010;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i     = 1'b1;
        rst_small = 1'b1;
        flush_i   = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #3;
        check("reset_valid", {31'b0, valid_o}, 32'd0);
        check("reset_cnt", {16'b0, stall_cnt_o}, 32'd0);
        check("reset_hazard", {31'b0, hazard_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // WBaddr selection and data pass-through.
        drive(5'd1, 5'd5, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        #1 check("wb_hazard0", {31'b0, hazard_o}, 32'd0);
        tick();
        exp_v = exp_q.pop_front();
        check("wb_rd_sel", {27'b0, WBaddr_o}, 32'd12);
        check("wb_rsdata", RSdata_o, exp_v);
        check("wb_valid", {31'b0, valid_o}, 32'd1);
        check("wb_aluop", {30'b0, ALUOp_o}, 32'd2);
        check("wb_rtaddr", {27'b0, RTaddr_o}, 32'd5);
        drive(5'd1, 5'd5, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678);
        exp_q.push_back(32'h12345678);
        tick();
        exp_v = exp_q.pop_front();
        check("wb_rt_sel", {27'b0, WBaddr_o}, 32'd5);
        check("wb_rsdata2", RSdata_o, exp_v);

        // Load-use: lw $8, then add $9,$8,$3.
        drive(5'd2, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
        #1 check("lu_lw_nohaz", {31'b0, hazard_o}, 32'd0);
        tick();
        check("lu_lw_memread", {31'b0, MemRead_o}, 32'd1);
        check("lu_lw_wb", {27'b0, WBaddr_o}, 32'd8);
        drive(5'd8, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200);
        #1 check("lu_hazard", {31'b0, hazard_o}, 32'd1);
        tick();
        check("lu_bub_valid", {31'b0, valid_o}, 32'd0);
        check("lu_bub_regwrite", {31'b0, RegWrite_o}, 32'd0);
        check("lu_bub_memread", {31'b0, MemRead_o}, 32'd0);
        check("lu_bub_rsaddr", {27'b0, RSaddr_o}, 32'd0);
        check("lu_bub_aluop", {30'b0, ALUOp_o}, 32'd0);
        check("lu_cnt1", {16'b0, stall_cnt_o}, 32'd1);
        check("lu_hazard_clr", {31'b0, hazard_o}, 32'd0);
        tick();
        check("lu_add_rsaddr", {27'b0, RSaddr_o}, 32'd8);
        check("lu_add_valid", {31'b0, valid_o}, 32'd1);
        check("lu_add_wb", {27'b0, WBaddr_o}, 32'd9);
        check("lu_cnt_hold", {16'b0, stall_cnt_o}, 32'd1);

        // No false stall: lw $0 then a reader of $0.
        drive(5'd2, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300);
        tick();
        drive(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400);
        #1 check("nfs_zero_haz", {31'b0, hazard_o}, 32'd0);
        tick();
        check("nfs_zero_valid", {31'b0, valid_o}, 32'd1);
        // lw $8 then a reader of $9/$10.
        drive(5'd2, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h500);
        tick();
        drive(5'd9, 5'd10, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h600);
        #1 check("nfs_indep_haz", {31'b0, hazard_o}, 32'd0);
        tick();
        check("nfs_indep_valid", {31'b0, valid_o}, 32'd1);
        check("nfs_cnt", {16'b0, stall_cnt_o}, 32'd1);

        // Flush wins over a hazard: lw $8, then sw reading $8 with flush.
        drive(5'd2, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700);
        tick();
        drive(5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h800);
        flush_i = 1'b1;
        #1 check("fl_hazard", {31'b0, hazard_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        check("fl_rsaddr", {27'b0, RSaddr_o}, 32'd0);
        check("fl_rtaddr", {27'b0, RTaddr_o}, 32'd0);
        check("fl_wbaddr", {27'b0, WBaddr_o}, 32'd0);
        check("fl_memwrite", {31'b0, MemWrite_o}, 32'd0);
        check("fl_valid", {31'b0, valid_o}, 32'd0);
        check("fl_cnt", {16'b0, stall_cnt_o}, 32'd1);

        // Load then dependent load: one stall, then the second load proceeds.
        drive(5'd2, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h900);
        tick();
        drive(5'd8, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA00);
        #1 check("ll_hazard", {31'b0, hazard_o}, 32'd1);
        tick();
        check("ll_bubble", {31'b0, valid_o}, 32'd0);
        check("ll_hazard_clr", {31'b0, hazard_o}, 32'd0);
        tick();
        check("ll_memread", {31'b0, MemRead_o}, 32'd1);
        check("ll_rtaddr", {27'b0, RTaddr_o}, 32'd9);
        check("ll_cnt", {16'b0, stall_cnt_o}, 32'd2);

        // Saturation on the 2-bit instance; release its reset between edges.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        rst_small = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(5'd2, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hB00);
            tick();
            drive(5'd8, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC00);
            #1 check("sat_hazard", {31'b0, s_hazard_o}, 32'd1);
            tick();
            check("sat_small_cnt", {30'b0, s_stall_cnt_o}, (i < 3) ? 32'(i + 1) : 32'd3);
            check("sat_big_cnt", {16'b0, stall_cnt_o}, 32'(i + 3));
        end

        // Reset mid-stall.
        drive(5'd2, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD00);
        tick();
        drive(5'd8, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'hE00);
        #1 check("rst_pre_hazard", {31'b0, hazard_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("rst_hazard", {31'b0, hazard_o}, 32'd0);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_memread", {31'b0, MemRead_o}, 32'd0);
        check("rst_rtaddr", {27'b0, RTaddr_o}, 32'd0);
        check("rst_wbaddr", {27'b0, WBaddr_o}, 32'd0);
        check("rst_rsdata", RSdata_o, 32'd0);
        check("rst_cnt", {16'b0, stall_cnt_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'hF00);
        tick();
        check("post_rst_valid", {31'b0, valid_o}, 32'd1);
        check("post_rst_wb", {27'b0, WBaddr_o}, 32'd2);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
